// File: rtl/bit_index_freelist.sv
// 64-entry free-slot bitmap with a registered highest-free-index allocation candidate,
// one take and two indexed releases per cycle, plus sticky misuse flags.
module bit_index_freelist #(
    parameter logic [63:0] INIT_FREE = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        alloc_vld,
    output logic [5:0]  alloc_idx,
    input  logic        alloc_take,
    input  logic        free0_en,
    input  logic [5:0]  free0_idx,
    input  logic        free1_en,
    input  logic [5:0]  free1_idx,
    output logic [63:0] free_map,
    output logic [6:0]  free_cnt,
    output logic        dbl_free_err,
    output logic        take_err
);

    function automatic logic [5:0] highest_set(input logic [63:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) r = 6'(i);
        end
        return r;
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    logic [63:0] map_q, map_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        vld_q, vld_d;
    logic [5:0]  idx_q, idx_d;
    logic        dbl_q, dbl_d;
    logic        terr_q, terr_d;

    logic take_ok, free0_ok, free1_ok;

    always_comb begin
        take_ok  = alloc_take & vld_q;
        // Release checks look at the pre-take map, so releasing the slot being taken
        // in the same cycle counts as a double free.
        free0_ok = free0_en & ~map_q[free0_idx];
        free1_ok = free1_en & ~map_q[free1_idx] & ~(free0_ok & (free0_idx == free1_idx));

        map_d = map_q;
        if (take_ok)  map_d[idx_q]     = 1'b0;
        if (free0_ok) map_d[free0_idx] = 1'b1;
        if (free1_ok) map_d[free1_idx] = 1'b1;

        cnt_d = cnt_q - {6'd0, take_ok} + {6'd0, free0_ok} + {6'd0, free1_ok};

        vld_d = |map_d;
        idx_d = highest_set(map_d);

        dbl_d  = dbl_q | (free0_en & ~free0_ok) | (free1_en & ~free1_ok);
        terr_d = terr_q | (alloc_take & ~vld_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q  <= INIT_FREE;
            cnt_q  <= popcount(INIT_FREE);
            vld_q  <= |INIT_FREE;
            idx_q  <= highest_set(INIT_FREE);
            dbl_q  <= 1'b0;
            terr_q <= 1'b0;
        end else begin
            map_q  <= map_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            dbl_q  <= dbl_d;
            terr_q <= terr_d;
        end
    end

    assign alloc_vld    = vld_q;
    assign alloc_idx    = idx_q;
    assign free_map     = map_q;
    assign free_cnt     = cnt_q;
    assign dbl_free_err = dbl_q;
    assign take_err     = terr_q;

endmodule

// File: tb/tb_bit_index_freelist.sv
// Directed and random checks of bit_index_freelist against a set-of-free-slots model.
module tb_bit_index_freelist;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_vld;
    logic [5:0]  alloc_idx;
    logic        alloc_take;
    logic        free0_en;
    logic [5:0]  free0_idx;
    logic        free1_en;
    logic [5:0]  free1_idx;
    logic [63:0] free_map;
    logic [6:0]  free_cnt;
    logic        dbl_free_err;
    logic        take_err;

    int checks = 0;
    int errors = 0;

    // Reference state: which slots are free, plus the two sticky flags.
    bit m_free [64];
    bit m_dbl, m_terr;

    always #5 clk = ~clk;

    bit_index_freelist dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_vld    (alloc_vld),
        .alloc_idx    (alloc_idx),
        .alloc_take   (alloc_take),
        .free0_en     (free0_en),
        .free0_idx    (free0_idx),
        .free1_en     (free1_en),
        .free1_idx    (free1_idx),
        .free_map     (free_map),
        .free_cnt     (free_cnt),
        .dbl_free_err (dbl_free_err),
        .take_err     (take_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 64; i++) n += m_free[i];
        return n;
    endfunction

    // Largest free slot number, -1 when nothing is free.
    function automatic int model_top();
        for (int i = 63; i >= 0; i--) if (m_free[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_bits();
        logic [63:0] b = '0;
        for (int i = 0; i < 64; i++) if (m_free[i]) b = b | (64'd1 << i);
        return b;
    endfunction

    task automatic check_all();
        int top;
        top = model_top();
        chk("free_map", free_map, model_bits());
        chk("free_cnt", 64'(free_cnt), 64'(model_count()));
        chk("cnt_vs_popcount", 64'(free_cnt), 64'($countones(free_map)));
        chk("alloc_vld", 64'(alloc_vld), 64'(top >= 0));
        chk("alloc_idx", 64'(alloc_idx), 64'(top >= 0 ? top : 0));
        chk("dbl_free_err", 64'(dbl_free_err), 64'(m_dbl));
        chk("take_err", 64'(take_err), 64'(m_terr));
    endtask

    // Apply one cycle of stimulus, advance the model, then check all outputs.
    task automatic cycle(input bit r, input bit tk, input bit e0, input int i0,
                         input bit e1, input int i1);
        int  top;
        bit  ok0, ok1;
        rst = r; alloc_take = tk;
        free0_en = e0; free0_idx = 6'(i0);
        free1_en = e1; free1_idx = 6'(i1);
        @(posedge clk);
        if (r) begin
            foreach (m_free[i]) m_free[i] = 1'b1;
            m_dbl = 0; m_terr = 0;
        end else begin
            top = model_top();
            ok0 = e0 && !m_free[i0];
            ok1 = e1 && !m_free[i1] && !(ok0 && i0 == i1);
            if (e0 && !ok0) m_dbl = 1;
            if (e1 && !ok1) m_dbl = 1;
            if (tk && top < 0) m_terr = 1;
            if (tk && top >= 0) m_free[top] = 0;
            if (ok0) m_free[i0] = 1;
            if (ok1) m_free[i1] = 1;
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; alloc_take = 0; free0_en = 0; free0_idx = 0; free1_en = 0; free1_idx = 0;
        foreach (m_free[i]) m_free[i] = 1'b1;
        m_dbl = 0; m_terr = 0;

        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_idx", 64'(alloc_idx), 64'd63);
        chk("reset_cnt", 64'(free_cnt), 64'd64);

        // Drain: candidates must appear in descending order.
        for (int i = 0; i < 64; i++) begin
            chk("drain_seq", 64'(alloc_idx), 64'(63 - i));
            cycle(0, 1, 0, 0, 0, 0);
        end
        chk("empty_vld", 64'(alloc_vld), 64'd0);
        chk("empty_map", free_map, 64'd0);
        chk("empty_cnt", 64'(free_cnt), 64'd0);
        chk("empty_terr", 64'(take_err), 64'd0);

        cycle(0, 1, 0, 0, 0, 0);
        chk("take_empty_terr", 64'(take_err), 64'd1);
        chk("take_empty_map", free_map, 64'd0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("terr_sticky", 64'(take_err), 64'd1);

        cycle(0, 0, 1, 5, 1, 40);
        chk("two_free_map", free_map, (64'd1 << 5) | (64'd1 << 40));
        chk("two_free_cnt", 64'(free_cnt), 64'd2);
        chk("two_free_idx", 64'(alloc_idx), 64'd40);
        cycle(0, 1, 0, 0, 0, 0);
        chk("after_take_idx", 64'(alloc_idx), 64'd5);

        cycle(0, 0, 1, 17, 1, 17);
        chk("same_idx_bit", 64'(free_map[17]), 64'd1);
        chk("same_idx_cnt", 64'(free_cnt), 64'd2);
        chk("same_idx_dbl", 64'(dbl_free_err), 64'd1);

        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_clears_terr", 64'(take_err), 64'd0);
        chk("rst_clears_dbl", 64'(dbl_free_err), 64'd0);
        for (int i = 0; i < 33; i++) cycle(0, 1, 0, 0, 0, 0);
        chk("pre_race_idx", 64'(alloc_idx), 64'd30);
        cycle(0, 1, 1, 30, 0, 0);
        chk("race_bit", 64'(free_map[30]), 64'd0);
        chk("race_cnt", 64'(free_cnt), 64'd30);
        chk("race_dbl", 64'(dbl_free_err), 64'd1);

        // Full map: any release is a double free.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 12);
        chk("full_dbl", 64'(dbl_free_err), 64'd1);

        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 799) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 63)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_index_freelist.md
# bit_index_freelist

Index-to-bitmap counterpart of the highest-set-bit finder. It keeps a registered 64-entry free bitmap and presents the highest free index as an allocation candidate every cycle. Each cycle it accepts one allocation take and up to two releases by 6-bit index, decoding each index to a one-hot update. It sits beside scheduler and allocator queues that hand out slot numbers and later return them by number.

## Interface
- INIT_FREE, 64'hFFFF_FFFF_FFFF_FFFF, free bitmap loaded at reset (1 = free).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- alloc_vld  out  1  at least one entry is free (registered).
- alloc_idx  out  6  highest-numbered free entry; 0 when alloc_vld=0 (registered).
- alloc_take  in  1  consumer takes alloc_idx this cycle.
- free0_en  in  1  release request, port 0.
- free0_idx  in  6  index released by port 0.
- free1_en  in  1  release request, port 1.
- free1_idx  in  6  index released by port 1.
- free_map  out  64  current free bitmap register.
- free_cnt  out  7  number of set bits in free_map, range 0..64.
- dbl_free_err  out  1  sticky: a release named an already-free index.
- take_err  out  1  sticky: alloc_take asserted while alloc_vld=0.

## Operation
- State is the bitmap register `map`, the counter `cnt`, the registered candidate (alloc_vld, alloc_idx), and the two sticky error flags.
- take_ok = alloc_take & alloc_vld.
  - take_ok clears bit alloc_idx.
  - alloc_take with alloc_vld=0 is ignored, except that it sets take_err.
- Port 0 release:
  - free0_ok = free0_en & ~map[free0_idx].
  - free0_en & map[free0_idx] is dropped and sets dbl_free_err.
- Port 1 release:
  - free1_ok = free1_en & ~map[free1_idx] & ~(free0_ok & free0_idx==free1_idx).
  - A failed port 1 release is dropped and sets dbl_free_err.
- All free checks use the current `map` value, before this cycle's take is applied.
  - Releasing the index being taken in the same cycle is therefore a double free: it is dropped and flagged, and the take still clears the bit.
- Next-state values:
  - map_next = (map & ~onehot(alloc_idx)·take_ok) | onehot(free0_idx)·free0_ok | onehot(free1_idx)·free1_ok.
  - cnt_next = cnt − take_ok + free0_ok + free1_ok, in 7-bit unsigned arithmetic. It never leaves 0..64, because failed operations are dropped.
- Candidate:
  - alloc_vld_next = |map_next.
  - alloc_idx_next = index of the highest set bit of map_next, or 0 if map_next is empty.
  - Registered together with map, so the outputs always describe free_map.
- free_cnt always equals popcount(free_map). A mismatch is a bug, and the bench asserts on it every cycle.
- Error flags are cleared only by rst.

## Timing
- Reset (rst=1 at an edge): map=INIT_FREE, cnt=popcount(INIT_FREE), alloc_vld=|INIT_FREE, alloc_idx=highest set index of INIT_FREE (63 for the default), dbl_free_err=0, take_err=0. rst overrides all requests in that cycle; an operation in flight is discarded.
- Take at edge N: the bit is clear in free_map from N+1, and the next candidate is presented at N+1. Back-to-back takes every cycle are legal, down to empty.
- Release at edge N: the bit is set at N+1, and it is the candidate at N+1 if it is the highest free index. A release from empty gives alloc_vld=1 the next cycle.
- Take plus two releases in one cycle are all applied at the same edge.
- Combinational paths: none from inputs to outputs; every output is a register.
- Full (cnt=64): every release is a double free. Empty (cnt=0): every take is a take_err.

## Test plan
- Reset with default INIT_FREE, then take for 64 consecutive cycles -> alloc_idx sequence 63,62,…,0; then alloc_vld=0, free_cnt=0, free_map=0, take_err=0.
- From empty: free0_idx=5 and free1_idx=40 in one cycle -> next cycle free_map has bits 5 and 40 set, free_cnt=2, alloc_idx=40; take -> alloc_idx=5 the cycle after.
- free0_idx=free1_idx=17 in one cycle while bit 17 is allocated -> bit 17 set, free_cnt +1, dbl_free_err=1.
- Take with alloc_idx=30 while free0_idx=30 in the same cycle -> bit 30 clear, free_cnt −1, dbl_free_err=1.
- alloc_take while empty -> take_err=1; map and cnt unchanged; take_err stays 1 until rst.
- Random take/free traffic for 10k cycles with rst pulses mid-stream -> free_cnt==popcount(free_map) every cycle; alloc_idx matches a reference highest-set-bit model; state returns to INIT_FREE one cycle after each rst.
